// File: rtl/moore_serial_tx.sv
// Moore serial frame transmitter: start bit 0, data LSB-first, optional even parity, stop bit 1.
// Every output is decoded from registered state; done is a registered one-cycle pulse.
module moore_serial_tx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]       CNT_LAST = 8'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic [7:0]        r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_done;
    logic              w_bit_end;
    logic              w_accept;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_accept  = (r_state == S_IDLE) && start;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        tx     = 1'b1;
        busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (w_bit_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                tx   = r_shift[0];
                busy = 1'b1;
                if (w_bit_end && (r_idx == IDX_LAST)) begin
                    if (PARITY_EN != 0) begin
                        w_next = S_PARITY;
                    end else begin
                        w_next = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                tx   = r_parity;
                busy = 1'b1;
                if (w_bit_end) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                busy = 1'b1;
                if (w_bit_end) begin
                    w_next = S_IDLE;
                end
            end
            // Unused encodings fall back to an idle line on the next edge.
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_STOP) && w_bit_end;
            if (w_accept) begin
                r_shift  <= data;
                r_parity <= ^data;
                r_cnt    <= '0;
            end else if (busy) begin
                r_cnt <= w_bit_end ? 8'd0 : r_cnt + 8'd1;
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == S_START) && w_bit_end) begin
                r_idx <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift <= r_shift >> 1;
                r_idx   <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_moore_serial_tx.sv
// Scoreboard bench for moore_serial_tx: defaults, no-parity and 4-cycle-bit instances.
// Each accepted frame pushes its per-cycle {tx,busy,done}; an empty queue means idle is expected.
module tb_moore_serial_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;
    logic [2:0] q0[$], q1[$], q2[$];
    logic [2:0] e0, e1, e2;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    moore_serial_tx #(.DATA_W(8), .PARITY_EN(1), .BIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .data(data),
        .tx(tx0), .busy(busy0), .done(done0));
    moore_serial_tx #(.DATA_W(8), .PARITY_EN(0), .BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .data(data),
        .tx(tx1), .busy(busy1), .done(done1));
    moore_serial_tx #(.DATA_W(8), .PARITY_EN(1), .BIT_CYCLES(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .data(data),
        .tx(tx2), .busy(busy2), .done(done2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int which, input logic [2:0] v);
        case (which)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    // Expected {tx,busy,done} for every cycle after the accepting edge.
    task automatic push_frame(input int which, input logic [7:0] d, input int pen, input int bc);
        for (int b = 0; b < 10 + pen; b++) begin
            logic bitv;
            if (b == 0)                bitv = 1'b0;
            else if (b <= 8)           bitv = d[b-1];
            else if (b == 9 && pen != 0) bitv = ^d;
            else                       bitv = 1'b1;
            for (int c = 0; c < bc; c++) push(which, {bitv, 1'b1, 1'b0});
        end
        push(which, 3'b101);
    endtask

    // Called at posedge+1; returns one cycle after the accepting edge.
    task automatic send(input logic [2:0] mask, input logic [7:0] d);
        data   = d;
        start0 = mask[0];
        start1 = mask[1];
        start2 = mask[2];
        @(posedge clk);
        if (mask[0]) push_frame(0, d, 1, 1);
        if (mask[1]) push_frame(1, d, 0, 1);
        if (mask[2]) push_frame(2, d, 1, 4);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        e0 = (q0.size() != 0) ? q0.pop_front() : 3'b100;
        e1 = (q1.size() != 0) ? q1.pop_front() : 3'b100;
        e2 = (q2.size() != 0) ? q2.pop_front() : 3'b100;
        chk("dut0_tx_busy_done", {29'd0, tx0, busy0, done0}, {29'd0, e0});
        chk("dut1_tx_busy_done", {29'd0, tx1, busy1, done1}, {29'd0, e1});
        chk("dut2_tx_busy_done", {29'd0, tx2, busy2, done2}, {29'd0, e2});
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        send(3'b001, 8'hA5);
        idle(15);

        send(3'b011, 8'h07);
        idle(15);

        send(3'b100, 8'h01);
        idle(50);

        // start during a frame is ignored, as is a later data change
        send(3'b001, 8'h00);
        idle(4);
        data   = 8'hFF;
        start0 = 1'b1;
        idle(1);
        start0 = 1'b0;
        idle(20);

        // reset at cycle 6 of a frame aborts it at once
        send(3'b001, 8'h5A);
        idle(5);
        rst = 1'b1;
        #1;
        chk("abort_tx", {31'd0, tx0}, 32'd1);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(15);

        // next frame requested in the done cycle of the previous one
        send(3'b001, 8'h81);
        idle(11);
        chk("b2b_done_cycle", {31'd0, done0}, 32'd1);
        send(3'b001, 8'h3C);
        idle(15);

        for (int i = 0; i < 3; i++) begin
            send(3'b111, 8'($urandom_range(0, 255)));
            idle(50);
        end

        chk("drain_q0", q0.size(), 32'd0);
        chk("drain_q1", q1.size(), 32'd0);
        chk("drain_q2", q2.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
